p_seq: RTL

//  Sequenced, multi-cycle unary/thermometer admission checker for wide vectors.

---
 rtl/p_seq.sv | 101 ++++++++++
 1 files changed

// File: rtl/p_seq.sv
// Sequenced unary/thermometer admission checker: captures a W-bit vector, scans
// it LSB-first in C-bit chunks over W/C beats, then reports admit + run length.
module p_seq #(
  parameter int W                     = 16,
  parameter int C                     = 4,
  parameter int P_ADMIT_COMPLIMENT_EN = 1,
  localparam int LW                   = $clog2(W)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_valid,
  input  logic [W-1:0]  i_x,
  output logic          o_ready,
  output logic          o_valid,
  output logic          o_is_unary,
  output logic [LW-1:0] o_len,
  input  logic          i_ready
);

  localparam int N     = W / C;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  // One spare bit so an all-ones/all-zeros run of length W cannot wrap to a small value.
  localparam int LEN_W = LW + 1;
  localparam logic EN_COMPL = (P_ADMIT_COMPLIMENT_EN != 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {PH_RUN, PH_TAIL, PH_BAD} phase_t;

  state_t           state, state_nxt;
  phase_t           phase, phase_scan;
  logic [W-1:0]     x_q;
  logic [CW-1:0]    cnt;
  logic             pol;
  logic [LEN_W-1:0] len, len_scan;
  logic             accept;
  logic             last_beat;
  logic             admit;

  assign o_ready   = (state == S_IDLE);
  assign o_valid   = (state == S_DONE);
  assign accept    = i_valid & o_ready;
  assign last_beat = (cnt == CW'(N - 1));

  // Scan the low C bits of the shifting capture register, carrying phase and len.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    phase_scan = phase;
    len_scan   = len;
    for (int b = 0; b < C; b++) begin
      case (phase_scan)
        PH_RUN:  if (x_q[b] == pol) len_scan = len_scan + LEN_W'(1);
                 else               phase_scan = PH_TAIL;
        PH_TAIL: if (x_q[b] == pol) phase_scan = PH_BAD;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)    state_nxt = S_BUSY;
      S_BUSY:  if (last_beat) state_nxt = S_DONE;
      S_DONE:  if (i_ready)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= S_IDLE;
      phase <= PH_RUN;
      len   <= '0;
      pol   <= 1'b0;
      cnt   <= '0;
      x_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_q   <= i_x;
        cnt   <= '0;
        pol   <= i_x[0];
        phase <= PH_RUN;
        len   <= '0;
      end else if (state == S_BUSY) begin
        x_q   <= x_q >> C;
        cnt   <= cnt + CW'(1);
        phase <= phase_scan;
        len   <= len_scan;
      end
    end
  end

  // Outputs decode held state only; nothing from i_* reaches o_* combinationally.
  assign admit      = (phase == PH_TAIL) & (pol | EN_COMPL);
  assign o_is_unary = o_valid & admit;
  assign o_len      = o_is_unary ? len[LW-1:0] : '0;

endmodule
